// File: rtl/grf_wb_sequencer.sv
// grf_wb_sequencer: single GRF write port arbiter.
// Merges W-stage writebacks and multi-cycle MDU results into one registered
// GRF write per cycle. MDU results that lose to a pipe write wait in an
// in-order FIFO; a pipe write to the same register squashes older queued
// MDU values so a stale result can never overwrite a newer one.
// Optional build macro: WB_TRACE_EN prints every committed GRF write.
module grf_wb_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_a3,
  input  logic [31:0] pipe_wd,
  input  logic [31:0] pipe_pc,
  input  logic        mdu_we,
  input  logic [4:0]  mdu_a3,
  input  logic [31:0] mdu_wd,
  input  logic [31:0] mdu_pc,
  output logic        mdu_ready,
  input  logic [4:0]  query_a1,
  input  logic [4:0]  query_a2,
  output logic        pending1,
  output logic        pending2,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [4:0]       fifo_a3 [DEPTH];
  logic [31:0]      fifo_wd [DEPTH];
  logic [31:0]      fifo_pc [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic pipe_emit;
  logic fifo_empty;
  logic mdu_live;
  logic pop;
  logic bypass;
  logic push;
  logic push_vld;

  // Readiness comes from the registered occupancy only, so a same-cycle pop never frees a slot early.
  assign mdu_ready = (count != FULL_CNT);

  // Arbitration: pipe beats queued results, queued results beat a fresh MDU result.
  always_comb begin
    pipe_emit  = pipe_we && (pipe_a3 != 5'd0);
    fifo_empty = (count == '0);
    mdu_live   = mdu_we && mdu_ready && (mdu_a3 != 5'd0);
    pop        = !pipe_emit && !fifo_empty;
    bypass     = !pipe_emit && fifo_empty && mdu_live;
    push       = mdu_live && !bypass;
    push_vld   = !(pipe_emit && (mdu_a3 == pipe_a3));
  end

  // Pending lookups for D-stage hazard detection; only live (valid) entries count.
  always_comb begin
    pending1 = 1'b0;
    pending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_a3[i] == query_a1) && (query_a1 != 5'd0)) pending1 = 1'b1;
      if (fifo_vld[i] && (fifo_a3[i] == query_a2) && (query_a2 != 5'd0)) pending2 = 1'b1;
    end
  end

  // FIFO control: pointers, occupancy and valid bits (squash, pop, push in that order of precedence).
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fifo_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_emit && (fifo_a3[i] == pipe_a3)) fifo_vld[i] <= 1'b0;
      end
      if (pop) begin
        fifo_vld[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (push) begin
        fifo_vld[tail] <= push_vld;
        tail           <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO payload storage; contents are meaningless unless the matching slot is occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a3[tail] <= mdu_a3;
      fifo_wd[tail] <= mdu_wd;
      fifo_pc[tail] <= mdu_pc;
    end
  end

  // Registered GRF write port; address/data/pc hold whenever nothing is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we <= 1'b0;
      grf_a3 <= 5'd0;
      grf_wd <= 32'd0;
      grf_pc <= 32'd0;
    end else begin
      grf_we <= 1'b0;
      if (pipe_emit) begin
        grf_we <= 1'b1;
        grf_a3 <= pipe_a3;
        grf_wd <= pipe_wd;
        grf_pc <= pipe_pc;
      end else if (pop) begin
        grf_we <= fifo_vld[head];
        if (fifo_vld[head]) begin
          grf_a3 <= fifo_a3[head];
          grf_wd <= fifo_wd[head];
          grf_pc <= fifo_pc[head];
        end
      end else if (bypass) begin
        grf_we <= 1'b1;
        grf_a3 <= mdu_a3;
        grf_wd <= mdu_wd;
        grf_pc <= mdu_pc;
      end
    end
  end

`ifdef WB_TRACE_EN
  // Commit trace of every GRF write.
  always @(posedge clk) begin
    if (!reset && grf_we) $display("@%h: $%d <= %h", grf_pc, grf_a3, grf_wd);
  end
`else
`endif

endmodule

// File: tb/tb_grf_wb_sequencer.sv
// Scoreboard bench for grf_wb_sequencer: directed stimulus pushes the
// hand-derived GRF writes in commit order; a monitor pops one entry per
// observed grf_we=1 cycle and compares.
module tb_grf_wb_sequencer;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we, mdu_we;
  logic [4:0]  pipe_a3, mdu_a3, query_a1, query_a2;
  logic [31:0] pipe_wd, pipe_pc, mdu_wd, mdu_pc;
  logic        mdu_ready, pending1, pending2, grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  grf_wb_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
    .mdu_we(mdu_we), .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
    .mdu_ready(mdu_ready), .query_a1(query_a1), .query_a2(query_a2),
    .pending1(pending1), .pending2(pending2),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    wr_t e;
    e.a3 = a3; e.wd = wd; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pwd, input logic [31:0] ppc,
                       input logic mw, input logic [4:0] ma, input logic [31:0] mwd, input logic [31:0] mpc);
    @(negedge clk);
    pipe_we = pw; pipe_a3 = pa; pipe_wd = pwd; pipe_pc = ppc;
    mdu_we  = mw; mdu_a3  = ma; mdu_wd  = mwd; mdu_pc  = mpc;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  // Monitor: every committed write must match the next expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (grf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got $%0d <= %h pc %h, expected no write", grf_a3, grf_wd, grf_pc);
        end else begin
          e = exp_q.pop_front();
          check("wr_a3", {27'd0, grf_a3}, {27'd0, e.a3});
          check("wr_wd", grf_wd, e.wd);
          check("wr_pc", grf_pc, e.pc);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    pipe_we = 1'b0; pipe_a3 = 5'd0; pipe_wd = 32'd0; pipe_pc = 32'd0;
    mdu_we = 1'b0; mdu_a3 = 5'd0; mdu_wd = 32'd0; mdu_pc = 32'd0;
    query_a1 = 5'd5; query_a2 = 5'd9;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    check("rst_grf_we", {31'd0, grf_we}, 32'd0);
    check("rst_grf_a3", {27'd0, grf_a3}, 32'd0);
    check("rst_grf_wd", grf_wd, 32'd0);
    check("rst_grf_pc", grf_pc, 32'd0);
    check("rst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
    check("rst_pending1", {31'd0, pending1}, 32'd0);
    check("rst_pending2", {31'd0, pending2}, 32'd0);

    // Plain pipe write, then an a3=0 request that must be dropped.
    drive(1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'd0, 32'd0);
    expect_wr(5'd5, 32'h1234, 32'h3000);
    drive(1'b1, 5'd0, 32'hDEAD, 32'h3004, 1'b0, 5'd0, 32'd0, 32'd0);
    idle();
    #1;
    check("a3zero_no_we", {31'd0, grf_we}, 32'd0);
    check("a3zero_hold_a3", {27'd0, grf_a3}, 32'd5);

    // Simultaneous pipe $8 and MDU $9: $9 queues behind.
    drive(1'b1, 5'd8, 32'h88, 32'h3008, 1'b1, 5'd9, 32'hAA, 32'h2000);
    expect_wr(5'd8, 32'h88, 32'h3008);
    expect_wr(5'd9, 32'hAA, 32'h2000);
    idle();
    query_a1 = 5'd9;
    #1;
    check("pend9_queued", {31'd0, pending1}, 32'd1);
    idle();
    #1;
    check("pend9_cleared", {31'd0, pending1}, 32'd0);
    repeat (2) idle();

    // Fill the FIFO while the pipe keeps the port busy.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'(20 + k), 32'h100 + 32'(k), 32'h3100 + 32'(4 * k),
            1'b1, 5'(12 + k), 32'hB0 + 32'(k), 32'h2100 + 32'(4 * k));
      expect_wr(5'(20 + k), 32'h100 + 32'(k), 32'h3100 + 32'(4 * k));
      #1;
      check("fill_ready", {31'd0, mdu_ready}, 32'd1);
    end
    drive(1'b1, 5'd24, 32'h104, 32'h3110, 1'b1, 5'd17, 32'hBAD, 32'h2110);
    expect_wr(5'd24, 32'h104, 32'h3110);
    #1;
    check("full_not_ready", {31'd0, mdu_ready}, 32'd0);
    idle();
    for (int k = 0; k < 4; k++) expect_wr(5'(12 + k), 32'hB0 + 32'(k), 32'h2100 + 32'(4 * k));
    query_a1 = 5'd12; query_a2 = 5'd15;
    #1;
    check("full_pend_head", {31'd0, pending1}, 32'd1);
    check("full_pend_tail", {31'd0, pending2}, 32'd1);
    check("full_still_not_ready", {31'd0, mdu_ready}, 32'd0);
    repeat (5) idle();
    #1;
    check("drained_ready", {31'd0, mdu_ready}, 32'd1);
    check("drained_pend", {31'd0, pending1}, 32'd0);

    // Squash: MDU $10=1 queued, then pipe $10=2 overrides it.
    drive(1'b1, 5'd3, 32'h33, 32'h3200, 1'b1, 5'd10, 32'h1, 32'h4000);
    expect_wr(5'd3, 32'h33, 32'h3200);
    drive(1'b1, 5'd10, 32'h2, 32'h4004, 1'b0, 5'd0, 32'd0, 32'd0);
    expect_wr(5'd10, 32'h2, 32'h4004);
    query_a1 = 5'd10;
    #1;
    check("squash_pend_before", {31'd0, pending1}, 32'd1);
    idle();
    #1;
    check("squash_pend_after", {31'd0, pending1}, 32'd0);
    idle();
    #1;
    check("squash_slot_we", {31'd0, grf_we}, 32'd0);
    check("squash_slot_a3", {27'd0, grf_a3}, 32'd10);

    // Bypass: lone MDU result with an empty FIFO writes directly.
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd11, 32'hCC, 32'h5000);
    expect_wr(5'd11, 32'hCC, 32'h5000);
    query_a1 = 5'd11;
    idle();
    #1;
    check("bypass_no_pend", {31'd0, pending1}, 32'd0);
    idle();

    // Reset with three queued entries discards them.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(21 + k), 32'h200 + 32'(k), 32'h3300 + 32'(4 * k),
            1'b1, 5'(27 + k), 32'hC0 + 32'(k), 32'h2300 + 32'(4 * k));
      expect_wr(5'(21 + k), 32'h200 + 32'(k), 32'h3300 + 32'(4 * k));
    end
    idle();
    reset = 1'b1;
    query_a1 = 5'd27;
    #1;
    check("prerst_pend", {31'd0, pending1}, 32'd1);
    idle();
    reset = 1'b0;
    #1;
    check("midrst_pend", {31'd0, pending1}, 32'd0);
    check("midrst_ready", {31'd0, mdu_ready}, 32'd1);
    check("midrst_we", {31'd0, grf_we}, 32'd0);
    check("midrst_a3", {27'd0, grf_a3}, 32'd0);
    check("midrst_wd", grf_wd, 32'd0);
    repeat (6) idle();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grf_wb_sequencer.md
Name: grf_wb_sequencer

Overview:
- Writer end of the GRF write port: merges writeback requests from the pipeline W stage and the multi-cycle MDU into one GRF write per cycle.
- Conflicting MDU results wait in a small in-order FIFO.
- Drives grf_we/grf_a3/grf_wd straight into the GRF write port, plus grf_pc for the trace.
- Exposes pending-write lookups so D-stage hazard logic can stall on registers whose values are still queued.

Parameters:
DEPTH, 4, MDU result FIFO entries (power of 2, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pipe_we  in  1  W-stage write request
pipe_a3  in  5  W-stage destination register
pipe_wd  in  32  W-stage write data
pipe_pc  in  32  W-stage instruction PC
mdu_we  in  1  MDU result request; accepted only when mdu_ready=1
mdu_a3  in  5  MDU destination register
mdu_wd  in  32  MDU result data
mdu_pc  in  32  PC of originating MDU instruction
mdu_ready  out  1  FIFO can accept (count < DEPTH)
query_a1  in  5  D-stage rs lookup
query_a2  in  5  D-stage rt lookup
pending1  out  1  query_a1 has a queued write
pending2  out  1  query_a2 has a queued write
grf_we  out  1  GRF write enable (registered)
grf_a3  out  5  GRF write address (registered)
grf_wd  out  32  GRF write data (registered)
grf_pc  out  32  PC of the write (registered)

Behaviour:
- Reset is synchronous and active-high on clk.
  - Clears the FIFO (count=0, pointers=0, all valid bits=0).
  - Forces grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0.
  - mdu_ready=1 after reset. Reset mid-queue discards all queued entries.
- Requests with a3=0 are ignored: no write, no enqueue. An MDU request with a3=0 still counts as accepted.
- Per cycle, evaluated on inputs sampled at posedge; grf_* outputs change one cycle later (latency 1).
- Output selection, highest priority first:
  1. pipe_we && pipe_a3!=0: emit pipe write.
  2. FIFO non-empty: pop head. Valid head emits its write; squashed head gives grf_we=0 that cycle.
  3. FIFO empty and accepted MDU request: emit MDU write directly (bypass, no enqueue).
  4. Otherwise: grf_we=0, other grf_* hold their last values.
- Enqueue: an accepted MDU request (mdu_we && mdu_ready, a3!=0) that is not bypassed is written at the tail with valid=1.
- Push and pop in the same cycle are allowed; count is unchanged.
- mdu_ready derives from the registered count only. When full there is no push, even if a pop occurs that cycle.
- Ordering: a pipe write is always the youngest.
  - When it emits with pipe_a3=R, every FIFO entry with a3=R has its valid bit cleared in the same cycle.
  - An MDU request pushed that same cycle with a3=R is stored with valid=0.
  - Result: a stale MDU value never overwrites a newer pipe value.
- FIFO pointers wrap modulo DEPTH. Entries drain strictly in order; squashed entries still consume one pop cycle.
- pending1 and pending2 are combinational.
  - pendingN=1 iff query_aN!=0 and some valid FIFO entry has a3==query_aN.
  - They do not reflect the registered grf_* outputs, which the GRF forwards internally.
- Simultaneous pipe and MDU requests: pipe emits; MDU is enqueued if ready, otherwise it holds its request.

Optional Feature:
- Macro: WB_TRACE_EN
- Defined: on every posedge with grf_we=1 and reset=0, the block prints `@%h: $%d <= %h` with grf_pc, grf_a3, grf_wd, using a simulation-only display.
- Undefined: no display statements are compiled. Logic is identical.

Test Plan:
- Reset then idle -> grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0, mdu_ready=1, pending1=pending2=0.
- pipe_we=1, a3=5, wd=0x1234, pc=0x3000 in one cycle -> next cycle grf_we=1, grf_a3=5, grf_wd=0x1234, grf_pc=0x3000; pipe_a3=0 -> grf_we=0.
- pipe write $8 and MDU write $9=0xAA in the same cycle -> cycle+1 writes $8; pending for $9=1 in between; cycle+2 writes $9=0xAA; pending then clears.
- Hold pipe_we busy while pushing 4 MDU results -> mdu_ready=0 after 4 accepts; a 5th request is not accepted; drains in order once pipe idles.
- MDU $10=0x1 queued, then pipe write $10=0x2 -> entry squashed, pending for $10 drops immediately; drain gives a grf_we=0 slot; final GRF $10=0x2.
- Assert reset with 3 queued entries -> next cycle count=0, mdu_ready=1, no further writes emitted.
